// File: rtl/mmcm_drp_pkg.sv
// Shared types and constants for the MMCM DRP reconfiguration controller.
package mmcm_drp_pkg;

  localparam int DRP_AW = 7;
  localparam int DRP_DW = 16;

  localparam logic [1:0] ERR_NONE = 2'd0;
  localparam logic [1:0] ERR_DRDY = 2'd1;
  localparam logic [1:0] ERR_LOCK = 2'd2;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_RST,
    ST_RD,
    ST_RD_WAIT,
    ST_WR,
    ST_WR_WAIT,
    ST_NEXT,
    ST_LOCK,
    ST_ERR
  } drp_state_t;

  typedef struct packed {
    logic [DRP_AW-1:0] addr;
    logic [DRP_DW-1:0] mask;
    logic [DRP_DW-1:0] data;
    logic              last;
  } drp_entry_t;

  // Read-modify-write merge: mask bits set keep the register, clear bits take new data.
  function automatic logic [DRP_DW-1:0] drp_merge(input logic [DRP_DW-1:0] rd,
                                                  input logic [DRP_DW-1:0] mask,
                                                  input logic [DRP_DW-1:0] data);
    return (rd & mask) | (data & ~mask);
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous level signal.
module sync_2ff (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  // Shift the asynchronous input through two flops to settle metastability.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/mmcm_drp_ctrl.sv
// Run-time MMCM reconfiguration through DRP: holds the MMCM in reset, applies
// a stream of read-modify-write register updates, then waits for lock.
module mmcm_drp_ctrl
  import mmcm_drp_pkg::*;
#(
  parameter int RST_HOLD     = 8,
  parameter int DRDY_TIMEOUT = 255,
  parameter int LOCK_TIMEOUT = 65535,
  parameter int SYNC_IGNORE  = 4
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [DRP_AW-1:0] s_addr,
  input  logic [DRP_DW-1:0] s_mask,
  input  logic [DRP_DW-1:0] s_data,
  input  logic              s_last,
  output logic              drp_den,
  output logic              drp_dwe,
  output logic [DRP_AW-1:0] drp_daddr,
  output logic [DRP_DW-1:0] drp_di,
  input  logic [DRP_DW-1:0] drp_do,
  input  logic              drp_drdy,
  output logic              mmcm_rst,
  input  logic              mmcm_locked,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [1:0]        err_code
);

  localparam int HOLD_W = $clog2(RST_HOLD + 1);
  localparam int WT_W   = $clog2(DRDY_TIMEOUT + 1);
  localparam int LK_W   = $clog2(LOCK_TIMEOUT + 1);

  localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(RST_HOLD - 1);
  localparam logic [WT_W-1:0]   WT_LAST   = WT_W'(DRDY_TIMEOUT - 1);
  localparam logic [LK_W-1:0]   LK_LAST   = LK_W'(LOCK_TIMEOUT - 1);
  localparam logic [LK_W-1:0]   LK_IGN    = LK_W'(SYNC_IGNORE);

  drp_state_t        state;
  drp_entry_t        entry;
  logic              alive;
  logic              locked_s;
  logic              accept;
  logic [HOLD_W-1:0] hold_cnt;
  logic [WT_W-1:0]   wait_cnt;
  logic [LK_W-1:0]   lock_cnt;

  sync_2ff u_lock_sync (
    .clk   (clk),
    .rst_n (resetn),
    .d     (mmcm_locked),
    .q     (locked_s)
  );

  // alive keeps s_ready low while reset is held and for the first edge after release.
  assign s_ready = alive && ((state == ST_IDLE) || (state == ST_NEXT));
  assign busy    = (state != ST_IDLE);
  assign accept  = s_valid && s_ready;

  // Register each accepted entry; payload only, so no reset is needed.
  always_ff @(posedge clk) begin
    if (accept) begin
      entry <= '{addr: s_addr, mask: s_mask, data: s_data, last: s_last};
    end
  end

  // Reconfiguration sequencer with registered DRP, reset and status outputs.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state     <= ST_IDLE;
      alive     <= 1'b0;
      drp_den   <= 1'b0;
      drp_dwe   <= 1'b0;
      drp_daddr <= '0;
      drp_di    <= '0;
      mmcm_rst  <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      err_code  <= ERR_NONE;
      hold_cnt  <= '0;
      wait_cnt  <= '0;
      lock_cnt  <= '0;
    end else begin
      alive   <= 1'b1;
      done    <= 1'b0;
      drp_den <= 1'b0;
      drp_dwe <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (accept) begin
            mmcm_rst <= 1'b1;
            err      <= 1'b0;
            err_code <= ERR_NONE;
            hold_cnt <= HOLD_LOAD;
            state    <= ST_RST;
          end
        end
        ST_RST: begin
          if (hold_cnt == '0) begin
            drp_den   <= 1'b1;
            drp_daddr <= entry.addr;
            state     <= ST_RD;
          end else begin
            hold_cnt <= hold_cnt - 1'b1;
          end
        end
        ST_RD: begin
          wait_cnt <= '0;
          state    <= ST_RD_WAIT;
        end
        ST_RD_WAIT: begin
          if (drp_drdy) begin
            drp_den <= 1'b1;
            drp_dwe <= 1'b1;
            drp_di  <= drp_merge(drp_do, entry.mask, entry.data);
            state   <= ST_WR;
          end else if (wait_cnt == WT_LAST) begin
            err_code <= ERR_DRDY;
            state    <= ST_ERR;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        ST_WR: begin
          wait_cnt <= '0;
          state    <= ST_WR_WAIT;
        end
        ST_WR_WAIT: begin
          if (drp_drdy) begin
            if (entry.last) begin
              mmcm_rst <= 1'b0;
              lock_cnt <= '0;
              state    <= ST_LOCK;
            end else begin
              state <= ST_NEXT;
            end
          end else if (wait_cnt == WT_LAST) begin
            err_code <= ERR_DRDY;
            state    <= ST_ERR;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        ST_NEXT: begin
          // MMCM is still in reset, so the next entry goes straight to its read.
          if (accept) begin
            drp_den   <= 1'b1;
            drp_daddr <= s_addr;
            state     <= ST_RD;
          end
        end
        ST_LOCK: begin
          // The synced lock may still be stale from before the reset; ignore it briefly.
          if ((lock_cnt >= LK_IGN) && locked_s) begin
            done  <= 1'b1;
            state <= ST_IDLE;
          end else if (lock_cnt == LK_LAST) begin
            err_code <= ERR_LOCK;
            state    <= ST_ERR;
          end else begin
            lock_cnt <= lock_cnt + 1'b1;
          end
        end
        ST_ERR: begin
          err   <= 1'b1;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mmcm_drp_ctrl.sv
// Self-checking bench for mmcm_drp_ctrl with a DRP register-file model and MMCM lock model.
`timescale 1ns/1ps
module tb_mmcm_drp_ctrl;

  localparam int RST_HOLD     = 8;
  localparam int DRDY_TIMEOUT = 255;
  localparam int LOCK_TIMEOUT = 100;
  localparam int SYNC_IGNORE  = 4;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        s_valid = 1'b0;
  logic        s_ready;
  logic [6:0]  s_addr = '0;
  logic [15:0] s_mask = '0;
  logic [15:0] s_data = '0;
  logic        s_last = 1'b0;
  logic        drp_den, drp_dwe;
  logic [6:0]  drp_daddr;
  logic [15:0] drp_di;
  logic [15:0] drp_do = '0;
  logic        drp_drdy = 1'b0;
  logic        mmcm_rst;
  logic        mmcm_locked = 1'b0;
  logic        busy, done, err;
  logic [1:0]  err_code;

  always #5 clk = ~clk;

  mmcm_drp_ctrl #(
    .RST_HOLD     (RST_HOLD),
    .DRDY_TIMEOUT (DRDY_TIMEOUT),
    .LOCK_TIMEOUT (LOCK_TIMEOUT),
    .SYNC_IGNORE  (SYNC_IGNORE)
  ) dut (
    .clk         (clk),
    .resetn      (resetn),
    .s_valid     (s_valid),
    .s_ready     (s_ready),
    .s_addr      (s_addr),
    .s_mask      (s_mask),
    .s_data      (s_data),
    .s_last      (s_last),
    .drp_den     (drp_den),
    .drp_dwe     (drp_dwe),
    .drp_daddr   (drp_daddr),
    .drp_di      (drp_di),
    .drp_do      (drp_do),
    .drp_drdy    (drp_drdy),
    .mmcm_rst    (mmcm_rst),
    .mmcm_locked (mmcm_locked),
    .busy        (busy),
    .done        (done),
    .err         (err),
    .err_code    (err_code)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_range(input string name, input int act, input int lo, input int hi);
    checks++;
    if (act < lo || act > hi) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d..%0d", name, act, lo, hi);
    end
  endtask

  // DRP register file, MMCM lock model and event counters (all driven on negedge)
  logic [15:0] mem     [128];
  logic [15:0] ref_mem [128];
  int          drdy_lat  = 3;   // 0: never answer
  int          lock_mode = 0;   // 0: lock after release, 1: never, 2: always high
  bit          pend = 0;
  int          pend_cnt = 0;
  logic [15:0] pend_do = '0;
  int          lock_dly = 0;
  int          den_cnt, wr_cnt, done_cnt, hold_cyc;
  bit          first_den;
  int          overlap_cnt = 0;
  int          rst_low_wr = 0;
  logic [6:0]  last_wr_addr, last_rd_addr;
  logic [15:0] last_wr_data;

  always @(negedge clk) begin
    drp_drdy = 1'b0;
    if (!resetn) pend = 0;
    if (pend) begin
      if (pend_cnt <= 1) begin
        drp_drdy = 1'b1;
        drp_do   = pend_do;
        pend     = 0;
      end else begin
        pend_cnt--;
      end
    end
    if (mmcm_rst && !first_den && !drp_den) hold_cyc++;
    if (drp_den) begin
      den_cnt++;
      first_den = 1;
      if (pend) overlap_cnt++;
      if (drp_dwe) begin
        mem[drp_daddr] = drp_di;
        wr_cnt++;
        last_wr_addr = drp_daddr;
        last_wr_data = drp_di;
        if (!mmcm_rst) rst_low_wr++;
        pend_do = 16'h0000;
      end else begin
        last_rd_addr = drp_daddr;
        pend_do = mem[drp_daddr];
      end
      if (drdy_lat > 0) begin
        pend     = 1;
        pend_cnt = drdy_lat;
      end
    end
    if (done) done_cnt++;
    case (lock_mode)
      0: begin
        if (mmcm_rst) begin
          mmcm_locked = 1'b0;
          lock_dly    = 0;
        end else if (lock_dly < 6) begin
          lock_dly++;
        end else begin
          mmcm_locked = 1'b1;
        end
      end
      1:       mmcm_locked = 1'b0;
      default: mmcm_locked = 1'b1;
    endcase
  end

  task automatic clear_mon();
    @(posedge clk);
    #1;
    den_cnt = 0; wr_cnt = 0; done_cnt = 0; hold_cyc = 0; first_den = 0;
  endtask

  bit ready_after;

  task automatic send(input logic [6:0] a, input logic [15:0] m, input logic [15:0] d, input bit last);
    int t;
    t = 0;
    @(negedge clk);
    s_valid = 1'b1; s_addr = a; s_mask = m; s_data = d; s_last = last;
    while (!s_ready && t < 2000) begin
      @(negedge clk);
      t++;
    end
    check("send_accept", 32'(t < 2000), 32'd1);
    @(negedge clk);
    s_valid = 1'b0;
    ready_after = s_ready;
  endtask

  task automatic wait_end(input int maxc, output int cyc);
    cyc = 0;
    while (!done && !err && cyc < maxc) begin
      @(negedge clk);
      cyc++;
    end
    check("end_within_budget", 32'(cyc < maxc), 32'd1);
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready(input int maxc);
    int t;
    t = 0;
    while (!s_ready && t < maxc) begin
      @(negedge clk);
      t++;
    end
    check("ready_within_budget", 32'(t < maxc), 32'd1);
  endtask

  function automatic logic [15:0] apply_rule(input logic [15:0] old, input logic [15:0] m,
                                              input logic [15:0] d);
    logic [15:0] r;
    for (int b = 0; b < 16; b++) r[b] = m[b] ? old[b] : d[b];
    return r;
  endfunction

  typedef struct {
    logic [6:0]  addr;
    logic [15:0] mask;
    logic [15:0] data;
    logic [15:0] init;
    logic [15:0] exp;
  } vec_t;

  vec_t vecs [5];

  initial begin
    int cyc, n, gap_low, nent;
    logic [6:0]  a;
    logic [15:0] m, d;
    logic [6:0]  addrs [$];

    vecs[0] = '{addr: 7'h08, mask: 16'hF000, data: 16'h0104, init: 16'hA3C3, exp: 16'hA104};
    vecs[1] = '{addr: 7'h09, mask: 16'hFFFF, data: 16'h1234, init: 16'h5A5A, exp: 16'h5A5A};
    vecs[2] = '{addr: 7'h14, mask: 16'h0000, data: 16'hBEEF, init: 16'h1111, exp: 16'hBEEF};
    vecs[3] = '{addr: 7'h7F, mask: 16'h00FF, data: 16'h1234, init: 16'hABCD, exp: 16'h12CD};
    vecs[4] = '{addr: 7'h00, mask: 16'hAAAA, data: 16'hFFFF, init: 16'h0000, exp: 16'h5555};

    for (int i = 0; i < 128; i++) begin
      mem[i]     = 16'($urandom);
      ref_mem[i] = mem[i];
    end

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_s_ready", 32'(s_ready), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_mmcm_rst", 32'(mmcm_rst), 0);
    check("rst_den_dwe", 32'({drp_den, drp_dwe}), 0);
    check("rst_daddr_di", 32'({drp_daddr, drp_di}), 0);
    check("rst_status", 32'({done, err, err_code}), 0);
    resetn = 1'b1;
    repeat (2) @(negedge clk);
    check("post_rst_ready", 32'(s_ready), 1);

    // Table-driven single-entry reconfigurations
    drdy_lat = 3; lock_mode = 0;
    for (int i = 0; i < 5; i++) begin
      mem[vecs[i].addr]     = vecs[i].init;
      ref_mem[vecs[i].addr] = vecs[i].init;
      clear_mon();
      send(vecs[i].addr, vecs[i].mask, vecs[i].data, 1'b1);
      check($sformatf("v%0d_ready_low", i), 32'(ready_after), 0);
      wait_end(500, cyc);
      check($sformatf("v%0d_wr_data", i), 32'(last_wr_data), 32'(vecs[i].exp));
      check($sformatf("v%0d_wr_addr", i), 32'(last_wr_addr), 32'(vecs[i].addr));
      check($sformatf("v%0d_rd_addr", i), 32'(last_rd_addr), 32'(vecs[i].addr));
      check($sformatf("v%0d_den_cnt", i), den_cnt, 2);
      check($sformatf("v%0d_wr_cnt", i), wr_cnt, 1);
      check($sformatf("v%0d_hold", i), hold_cyc, RST_HOLD);
      check($sformatf("v%0d_done_cnt", i), done_cnt, 1);
      check($sformatf("v%0d_status", i), 32'({err, err_code, mmcm_rst, busy}), 0);
      ref_mem[vecs[i].addr] = vecs[i].exp;
    end

    // Three entries with 20-cycle gaps between them
    clear_mon();
    for (int k = 0; k < 3; k++) begin
      a = (k == 0) ? 7'h08 : (k == 1) ? 7'h09 : 7'h14;
      m = 16'($urandom); d = 16'($urandom);
      ref_mem[a] = apply_rule(ref_mem[a], m, d);
      send(a, m, d, k == 2);
      check($sformatf("multi%0d_ready_low", k), 32'(ready_after), 0);
      if (k < 2) begin
        wait_ready(200);
        gap_low = 0;
        repeat (20) begin
          @(negedge clk);
          if (!mmcm_rst || !busy) gap_low++;
        end
        check($sformatf("multi%0d_gap_rst_high", k), gap_low, 0);
      end
    end
    wait_end(800, cyc);
    check("multi_den_cnt", den_cnt, 6);
    check("multi_wr_cnt", wr_cnt, 3);
    check("multi_hold", hold_cyc, RST_HOLD);
    check("multi_done_cnt", done_cnt, 1);
    check("multi_mem08", 32'(mem[7'h08]), 32'(ref_mem[7'h08]));
    check("multi_mem09", 32'(mem[7'h09]), 32'(ref_mem[7'h09]));
    check("multi_mem14", 32'(mem[7'h14]), 32'(ref_mem[7'h14]));

    // DRDY never returned
    drdy_lat = 0;
    clear_mon();
    send(7'h10, 16'h0F0F, 16'h1234, 1'b1);
    wait_end(600, cyc);
    check_range("drdy_timeout_cycles", cyc - RST_HOLD, DRDY_TIMEOUT, DRDY_TIMEOUT + 3);
    check("drdy_err", 32'(err), 1);
    check("drdy_err_code", 32'(err_code), 1);
    check("drdy_mmcm_rst", 32'(mmcm_rst), 1);
    check("drdy_busy", 32'(busy), 0);
    check("drdy_no_done", done_cnt, 0);
    drdy_lat = 2;
    clear_mon();
    ref_mem[7'h10] = apply_rule(ref_mem[7'h10], 16'h0F0F, 16'h1234);
    send(7'h10, 16'h0F0F, 16'h1234, 1'b1);
    check("recover_err_clear", 32'({err, err_code}), 0);
    wait_end(500, cyc);
    check("recover_done_cnt", done_cnt, 1);
    check("recover_mem", 32'(mem[7'h10]), 32'(ref_mem[7'h10]));

    // Lock never asserted
    lock_mode = 1;
    clear_mon();
    ref_mem[7'h21] = apply_rule(ref_mem[7'h21], 16'hFF00, 16'h00AA);
    send(7'h21, 16'hFF00, 16'h00AA, 1'b1);
    wait_end(800, cyc);
    check("lock_err", 32'(err), 1);
    check("lock_err_code", 32'(err_code), 2);
    check("lock_mmcm_rst", 32'(mmcm_rst), 0);
    check("lock_no_done", done_cnt, 0);
    check("lock_mem", 32'(mem[7'h21]), 32'(ref_mem[7'h21]));

    // Stale lock: locked stays high through the whole update
    lock_mode = 2;
    clear_mon();
    ref_mem[7'h22] = apply_rule(ref_mem[7'h22], 16'h0000, 16'h5AA5);
    send(7'h22, 16'h0000, 16'h5AA5, 1'b1);
    n = 0;
    while (mmcm_rst && n < 1000) begin
      @(negedge clk);
      n++;
    end
    n = 0;
    while (!done && n < 200) begin
      @(negedge clk);
      n++;
    end
    check_range("stale_lock_delay", n, SYNC_IGNORE, SYNC_IGNORE + 2);
    @(posedge clk);
    #1;
    check("stale_done_cnt", done_cnt, 1);
    check("stale_mem", 32'(mem[7'h22]), 32'(ref_mem[7'h22]));

    // Reset asserted while a read is outstanding
    lock_mode = 0; drdy_lat = 0;
    clear_mon();
    send(7'h33, 16'h1234, 16'h4321, 1'b1);
    n = 0;
    while (!drp_den && n < 100) begin
      @(negedge clk);
      n++;
    end
    repeat (3) @(negedge clk);
    check("midrst_busy_before", 32'(busy), 1);
    resetn = 1'b0;
    #1;
    check("midrst_ctrl", 32'({s_ready, busy, mmcm_rst, done, err, err_code}), 0);
    check("midrst_drp", 32'({drp_den, drp_dwe, drp_daddr, drp_di}), 0);
    @(negedge clk);
    resetn = 1'b1;
    repeat (2) @(negedge clk);
    check("midrst_ready_after", 32'(s_ready), 1);
    check("midrst_busy_after", 32'(busy), 0);
    drdy_lat = 3;
    clear_mon();
    ref_mem[7'h33] = apply_rule(ref_mem[7'h33], 16'h1234, 16'h4321);
    send(7'h33, 16'h1234, 16'h4321, 1'b1);
    wait_end(500, cyc);
    check("midrst_recover_done", done_cnt, 1);
    check("midrst_recover_mem", 32'(mem[7'h33]), 32'(ref_mem[7'h33]));

    // Randomized multi-entry reconfigurations against the register-file reference
    for (int it = 0; it < 25; it++) begin
      nent = $urandom_range(1, 4);
      drdy_lat = $urandom_range(1, 6);
      addrs.delete();
      clear_mon();
      for (int k = 0; k < nent; k++) begin
        a = 7'($urandom_range(0, 127));
        m = 16'($urandom);
        d = 16'($urandom);
        ref_mem[a] = apply_rule(ref_mem[a], m, d);
        addrs.push_back(a);
        repeat ($urandom_range(0, 5)) @(negedge clk);
        send(a, m, d, k == nent - 1);
      end
      wait_end(2000, cyc);
      check($sformatf("rnd%0d_done", it), done_cnt, 1);
      check($sformatf("rnd%0d_den_cnt", it), den_cnt, 2 * nent);
      check($sformatf("rnd%0d_status", it), 32'({err, err_code, mmcm_rst}), 0);
      foreach (addrs[j])
        check($sformatf("rnd%0d_mem_%0h", it, addrs[j]), 32'(mem[addrs[j]]), 32'(ref_mem[addrs[j]]));
    end

    check("no_overlapping_den", overlap_cnt, 0);
    check("no_write_with_rst_low", rst_low_wr, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
    $fatal(1);
  end

endmodule

// File: doc/mmcm_drp_ctrl.md
Name: mmcm_drp_ctrl

Overview:
- Reconfigures the TX MMCM (MMCME4) at run time through its DRP port, so the line rate and the x4 serial clock can change without a bitstream reload.
- Accepts a stream of register-update entries (address, keep-mask, data) from the control logic and holds the MMCM in reset for the whole update.
- Performs a DRP read-modify-write for each entry, then releases reset and waits for lock with a timeout.
- Sits beside the clock generator in the DRP clock domain; reports done or error to the host.

Parameters:
- RST_HOLD, 8, cycles mmcm_rst is held before the first DRP access.
- DRDY_TIMEOUT, 255, maximum cycles to wait for drp_drdy per access.
- LOCK_TIMEOUT, 65535, maximum cycles to wait for lock after reset release.
- SYNC_IGNORE, 4, cycles after reset release during which the synced lock is ignored.

Ports:
- clk  in  1  DRP/control clock; all logic is in this domain.
- resetn  in  1  asynchronous, active-low reset.
- s_valid  in  1  entry valid.
- s_ready  out  1  entry accepted when s_valid && s_ready.
- s_addr  in  7  DRP register address.
- s_mask  in  16  bits set to 1 keep the current register value.
- s_data  in  16  new bits, used where s_mask is 0.
- s_last  in  1  marks the final entry of a reconfiguration.
- drp_den  out  1  DRP enable, one-cycle pulse.
- drp_dwe  out  1  DRP write enable, valid together with drp_den.
- drp_daddr  out  7  DRP address.
- drp_di  out  16  DRP write data.
- drp_do  in  16  DRP read data, valid when drp_drdy is high.
- drp_drdy  in  1  DRP access complete.
- mmcm_rst  out  1  MMCM RST, active high.
- mmcm_locked  in  1  MMCM LOCKED; asynchronous to clk.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse on successful lock.
- err  out  1  sticky error flag.
- err_code  out  2  0 = none, 1 = DRDY timeout, 2 = lock timeout.

Behaviour:
- Reset values: all outputs 0, state IDLE, err_code 0. mmcm_rst resets to 0. A reset in the middle of a reconfiguration abandons it and leaves the MMCM running with whatever partial configuration it holds.
- mmcm_locked passes through a 2-FF synchronizer (locked_s) before use.
- s_ready is high only in IDLE and NEXT. An accepted entry is registered, along with its s_last flag.
- IDLE -> RST: on accept; assert mmcm_rst, clear err and err_code, load the hold counter.
- RST: after RST_HOLD cycles -> RD.
- RD: drive drp_den=1, drp_dwe=0, drp_daddr=addr for one cycle -> RD_WAIT.
- RD_WAIT: on drp_drdy, capture drp_do -> WR.
- WR: drp_den=1, drp_dwe=1, drp_di = (rd & mask) | (data & ~mask), one cycle -> WR_WAIT.
- WR_WAIT: on drp_drdy: if last -> LOCK; otherwise -> NEXT.
- NEXT: keep mmcm_rst asserted and wait indefinitely for s_valid; on accept -> RD (no second reset hold).
- LOCK: deassert mmcm_rst and load the timeout counter.
  - locked_s is ignored for the first SYNC_IGNORE cycles.
  - After that, locked_s=1 pulses done and returns to IDLE.
  - Counter expiry -> ERR with err_code=2.
- Both *_WAIT states count cycles. Reaching DRDY_TIMEOUT without drp_drdy -> ERR with err_code=1; mmcm_rst stays asserted.
- ERR: set err, go to IDLE next cycle. mmcm_rst remains as it was (1 for a DRDY error, 0 for a lock error) until the next accepted entry.
- drp_drdy outside the *_WAIT states is ignored. drp_den is never asserted while an access is outstanding.
- DRP pins toggle only in RD/WR; drp_daddr and drp_di hold their last value otherwise.
- Minimum latency for an entry, from accept to ready for the next: 4 cycles plus two DRDY latencies.

Decomposition:
- Package mmcm_drp_pkg holds:
  - the state enum;
  - the err_code constants ERR_NONE, ERR_DRDY, ERR_LOCK;
  - the DRP address/data width constants (7/16);
  - a drp_entry_t struct (addr, mask, data, last).
- One sub-module, sync_2ff, for mmcm_locked; it is reused elsewhere in the design.

Test Plan:
- Single entry (addr 0x08, mask 0xF000, data 0x0104), DRP model returns 0xA3C3 after 3 cycles -> one read pulse then a write of 0xA104 to 0x08; mmcm_rst high from accept through the write; done pulses once lock is raised.
- Three entries (0x08, 0x09, 0x14), last on the third, s_valid gapped by 20 cycles -> s_ready low between entries; mmcm_rst stays high across the gap; exactly 6 drp_den pulses; one reset hold of 8 cycles.
- DRP model never returns drdy -> ERR after 255 cycles; err=1, err_code=1, mmcm_rst=1, busy=0; the next entry clears err.
- Lock held low (LOCK_TIMEOUT set to 100 for sim) -> err_code=2, mmcm_rst=0, no done pulse.
- Stale lock: mmcm_locked left high throughout -> done is not asserted until SYNC_IGNORE cycles after release.
- resetn pulsed low during RD_WAIT -> all outputs 0 immediately; state IDLE; s_ready=1 after release.
